// File: rtl/sonar_mmio.sv
//============================================================================
// Module      : sonar_mmio
// Description : Memory-mapped ultrasonic ranger on the data-memory bus.
//               A store to CTRL fires a trigger pulse. The block then
//               measures the width of the returning echo pulse and posts
//               the result in RESULT.
//               Register map (word offsets from BASE_ADDR):
//                 0 CTRL   (W)  bit0=1 starts a ranging cycle
//                 1 STATUS (R)  {29'b0, timeout, done, busy}
//                 2 RESULT (R)  zero-extended measurement; a read
//                               clears done/timeout
//                 3 reserved    reads 0, writes ignored
//               Optional build macro SONAR_CM_CONV_EN: RESULT reports
//               centimetres (CYCLES_PER_CM clocks per cm, truncated)
//               instead of raw clock cycles.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module sonar_mmio #(
    parameter logic [11:0] BASE_ADDR      = 12'hF00,
    parameter int          TRIG_CYCLES    = 500,
    parameter int          TIMEOUT_CYCLES = 1500000,
    parameter int          CNT_W          = 24,
    parameter int          CYCLES_PER_CM  = 2900
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wren,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic        sel,
    output logic [31:0] q_out,
    output logic        trig,
    input  logic        echo,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TRIG      = 2'd1,
        S_WAIT_RISE = 2'd2,
        S_MEASURE   = 2'd3
    } state_t;

    // 13-bit window bounds so a BASE_ADDR near the top of the 12-bit
    // space cannot wrap the upper bound back to low addresses.
    localparam logic [12:0]      c_win_lo    = {1'b0, BASE_ADDR};
    localparam logic [12:0]      c_win_hi    = {1'b0, BASE_ADDR} + 13'd3;
    localparam logic [CNT_W-1:0] c_trig_last = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_tmo_last  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [1:0]       c_off_ctrl   = 2'd0;
    localparam logic [1:0]       c_off_status = 2'd1;
    localparam logic [1:0]       c_off_result = 2'd2;

    state_t             r_state;
    logic               r_trig;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_result;
    logic [31:0]        r_q;
    logic               r_echo_meta;
    logic               r_echo_s;
    logic               r_echo_s_d;

    logic [12:0]        w_addr;
    logic [1:0]         w_off;
    logic               w_rise;
    logic               w_start;
    logic               w_result_rd;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_meas;
    logic [31:0]        w_status;
    logic [31:0]        w_result_ext;
    logic               w_unused;

    // Only address[11:0] and data_in[0] carry meaning for this block.
    assign w_unused = ^{address[31:12], data_in[31:1]};

    // Address decode: window match and word offset within the window.
    assign w_addr = {1'b0, address[11:0]};
    assign sel    = (w_addr >= c_win_lo) && (w_addr <= c_win_hi);
    assign w_off  = address[1:0] - BASE_ADDR[1:0];

    // Bus strobes: any load in the window is a read (there is no read strobe).
    assign w_start     = wren & sel & (w_off == c_off_ctrl) & data_in[0];
    assign w_result_rd = ~wren & sel & (w_off == c_off_result);

    // Echo edge detect on the synchronised copy.
    assign w_rise = r_echo_s & ~r_echo_s_d;

    // Shared counter increments saturate instead of wrapping.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    assign w_status     = {29'b0, r_timeout, r_done, r_busy};
    assign w_result_ext = 32'(r_result);

`ifdef SONAR_CM_CONV_EN
    localparam logic [CNT_W-1:0] c_presc_last = CNT_W'(CYCLES_PER_CM - 1);

    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] r_cm;

    // Centimetre prescaler: advances on exactly the cycles the raw counter counts.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
            r_cm    <= '0;
        end else if (r_state == S_WAIT_RISE) begin
            r_presc <= '0;
            r_cm    <= '0;
        end else if ((r_state == S_MEASURE) && r_echo_s && (r_cnt != c_tmo_last)) begin
            if (r_presc == c_presc_last) begin
                r_presc <= '0;
                r_cm    <= (r_cm == c_cnt_max) ? r_cm : r_cm + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign w_meas = r_cm;
`else
    localparam int c_unused_cm = CYCLES_PER_CM;

    assign w_meas = r_cnt;
`endif

    // Two-flop synchroniser for the asynchronous echo, plus a delayed copy for edge detect.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
            r_echo_s_d  <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
            r_echo_s_d  <= r_echo_s;
        end
    end

    // Ranging FSM with registered trig/busy and the done/timeout/RESULT status.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_trig    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            // A RESULT read clears the sticky flags. Completion updates
            // further down are later assignments, so they win on the same edge.
            if (w_result_rd) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_trig    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (r_cnt == c_trig_last) begin
                        r_trig  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_RISE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_state <= S_MEASURE;
                    end else if (r_cnt == c_tmo_last) begin
                        r_result  <= c_cnt_max;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_MEASURE: begin
                    if (!r_echo_s) begin
                        r_result <= w_meas;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == c_tmo_last) begin
                        r_result  <= c_cnt_max;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_trig  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered read mux: one-cycle load latency, zero when not selected.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
        end else if (sel) begin
            case (w_off)
                c_off_status: r_q <= w_status;
                c_off_result: r_q <= w_result_ext;
                default:      r_q <= '0;
            endcase
        end else begin
            r_q <= '0;
        end
    end

    assign q_out = r_q;
    assign trig  = r_trig;
    assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sonar_mmio.sv
//============================================================================
// Module      : tb_sonar_mmio
// Description : Self-checking bench for sonar_mmio. Bus reads push their
//               expected value into a scoreboard queue. A monitor pops and
//               compares each entry once the registered q_out is valid.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sonar_mmio;

    localparam int TRIG_CYC = 10;
    localparam int TMO_CYC  = 1000;
`ifdef SONAR_CM_CONV_EN
    localparam int ECHO_LEN = 305;
    localparam int ECHO_EXP = 30;
    localparam int ECHO_TOL = 1;
    localparam int RT_EXP   = 5;
    localparam int RT_TOL   = 1;
`else
    localparam int ECHO_LEN = 300;
    localparam int ECHO_EXP = 300;
    localparam int ECHO_TOL = 2;
    localparam int RT_EXP   = 50;
    localparam int RT_TOL   = 2;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        wren;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        sel;
    logic [31:0] q_out;
    logic        trig;
    logic        echo;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_exp[$];
    int          sb_tol[$];
    string       sb_name[$];

    int   trig_hi_cyc = 0;
    int   trig_rises  = 0;
    logic trig_prev   = 1'b0;

    sonar_mmio #(
        .BASE_ADDR      (12'hF00),
        .TRIG_CYCLES    (TRIG_CYC),
        .TIMEOUT_CYCLES (TMO_CYC),
        .CNT_W          (24),
        .CYCLES_PER_CM  (10)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .wren    (wren),
        .address (address),
        .data_in (data_in),
        .sel     (sel),
        .q_out   (q_out),
        .trig    (trig),
        .echo    (echo),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    // Trigger monitor: high-cycle count and rising-edge count.
    always @(negedge clock) begin
        if (trig === 1'b1) trig_hi_cyc <= trig_hi_cyc + 1;
        if (trig === 1'b1 && trig_prev !== 1'b1) trig_rises <= trig_rises + 1;
        trig_prev <= trig;
    end

    // Scoreboard: a read issued before this edge is checked just after it.
    always @(posedge clock) begin : p_sb
        logic [31:0] e;
        int          t;
        string       nm;
        #1;
        if (sb_exp.size() > 0) begin
            e  = sb_exp.pop_front();
            t  = sb_tol.pop_front();
            nm = sb_name.pop_front();
            n_checks++;
            if (t == 0) begin
                if (q_out !== e) begin
                    n_fail++;
                    $display("FAIL %s: q_out=0x%08h expected 0x%08h", nm, q_out, e);
                end
            end else if ($isunknown(q_out) || (q_out + t < e) || (q_out > e + t)) begin
                n_fail++;
                $display("FAIL %s: q_out=%0d expected %0d +/- %0d", nm, q_out, e, t);
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a;
        data_in = d;
        wren    = 1'b1;
        @(posedge clock);
        #1;
        wren    = 1'b0;
        address = 32'h0;
        data_in = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp_v,
                            input int tol, input string nm);
        logic exp_sel;
        @(negedge clock);
        wren    = 1'b0;
        address = a;
        sb_exp.push_back(exp_v);
        sb_tol.push_back(tol);
        sb_name.push_back(nm);
        #1;
        exp_sel = (a[11:0] >= 12'hF00) && (a[11:0] <= 12'hF03);
        n_checks++;
        if (sel !== exp_sel) begin
            n_fail++;
            $display("FAIL sel_%s: sel=%b expected %b", nm, sel, exp_sel);
        end
    endtask

    task automatic bus_idle();
        @(negedge clock);
        address = 32'h0;
        wren    = 1'b0;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        wren    = 1'b0;
        address = 32'h0;
        data_in = 32'h0;
        echo    = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (trig !== 1'b0 || busy !== 1'b0 || q_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: trig=%b busy=%b q_out=0x%08h expected 0 0 0", trig, busy, q_out);
        end
        resetn = 1'b1;
        bus_read(32'h0000_0F01, 32'h0, 0, "reset_status");
        bus_read(32'h0000_0F02, 32'h0, 0, "reset_result");
        bus_idle();
    endtask

    task automatic test_measure();
        int h0, r0, n;
        h0 = trig_hi_cyc;
        r0 = trig_rises;
        bus_write(32'h0000_0F00, 32'h1);
        n_checks++;
        if (busy !== 1'b1 || trig !== 1'b1) begin
            n_fail++;
            $display("FAIL start_flags: busy=%b trig=%b expected 1 1", busy, trig);
        end
        repeat (20) @(negedge clock);
        #1;
        n_checks++;
        if ((trig_hi_cyc - h0) != TRIG_CYC || (trig_rises - r0) != 1) begin
            n_fail++;
            $display("FAIL trig_width: high=%0d pulses=%0d expected %0d 1",
                     trig_hi_cyc - h0, trig_rises - r0, TRIG_CYC);
        end
        echo = 1'b1;
        repeat (ECHO_LEN) @(negedge clock);
        echo = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL measure_end: busy=%b expected 0 within 20 cycles", busy);
        end
        bus_read(32'h0000_0F01, 32'h2, 0, "measure_status_done");
        bus_read(32'h0000_0F02, 32'(ECHO_EXP), ECHO_TOL, "measure_result");
        bus_read(32'h0000_0F01, 32'h0, 0, "measure_status_cleared");
        bus_idle();
    endtask

    task automatic test_timeout();
        int n;
        echo = 1'b0;
        bus_write(32'h0000_0F00, 32'h1);
        n = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            if (busy === 1'b1) n++;
            else break;
        end
        n_checks++;
        if (busy !== 1'b0 || n != TRIG_CYC + TMO_CYC) begin
            n_fail++;
            $display("FAIL timeout_busy_cycles: busy=%b cycles=%0d expected 0 %0d",
                     busy, n, TRIG_CYC + TMO_CYC);
        end
        bus_read(32'h0000_0F01, 32'h6, 0, "timeout_status");
        bus_read(32'h0000_0F02, 32'h00FF_FFFF, 0, "timeout_result");
        bus_idle();
    endtask

    task automatic test_back_to_back();
        bus_write(32'h0000_0F03, 32'hDEAD_BEEF);
        bus_write(32'h0000_0F02, 32'h0000_0055);
        bus_read(32'h0000_0F01, 32'h0,         0, "b2b_status_cleared");
        bus_read(32'h0000_0F02, 32'h00FF_FFFF, 0, "b2b_result_kept");
        bus_read(32'h0000_0F03, 32'h0,         0, "b2b_reserved");
        bus_read(32'h0000_0F04, 32'h0,         0, "b2b_above_window");
        bus_read(32'h0000_1F02, 32'h00FF_FFFF, 0, "b2b_upper_bits_ignored");
        bus_read(32'h0000_0EFF, 32'h0,         0, "b2b_below_window");
        bus_idle();
    endtask

    task automatic test_retrigger_ignored();
        int h0, r0, n;
        h0 = trig_hi_cyc;
        r0 = trig_rises;
        bus_write(32'h0000_0F00, 32'h1);
        repeat (3) @(negedge clock);
        bus_write(32'h0000_0F00, 32'h1);
        repeat (20) @(negedge clock);
        #1;
        n_checks++;
        if ((trig_hi_cyc - h0) != TRIG_CYC || (trig_rises - r0) != 1) begin
            n_fail++;
            $display("FAIL retrigger_pulse: high=%0d pulses=%0d expected %0d 1",
                     trig_hi_cyc - h0, trig_rises - r0, TRIG_CYC);
        end
        echo = 1'b1;
        repeat (50) @(negedge clock);
        echo = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL retrigger_end: busy=%b expected 0 within 20 cycles", busy);
        end
        bus_read(32'h0000_0F01, 32'h2, 0, "retrigger_status");
        bus_read(32'h0000_0F02, 32'(RT_EXP), RT_TOL, "retrigger_result");
        bus_idle();
    endtask

    task automatic test_reset_mid_measure();
        // Reset during TRIG: trig must drop without waiting for a clock edge.
        bus_write(32'h0000_0F00, 32'h1);
        repeat (4) @(negedge clock);
        #2;
        n_checks++;
        if (trig !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_trig: trig=%b expected 1", trig);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if (trig !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_trig: trig=%b busy=%b expected 0 0", trig, busy);
        end
        @(negedge clock);
        resetn = 1'b1;
        // Reset during MEASURE while STATUS is being read continuously.
        bus_write(32'h0000_0F00, 32'h1);
        repeat (20) @(negedge clock);
        echo = 1'b1;
        repeat (50) @(negedge clock);
        address = 32'h0000_0F01;
        @(posedge clock);
        #1;
        n_checks++;
        if (q_out !== 32'h1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL measure_busy_status: q_out=0x%08h busy=%b expected 0x00000001 1", q_out, busy);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (q_out !== 32'h0 || trig !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_measure: q_out=0x%08h trig=%b busy=%b expected 0 0 0", q_out, trig, busy);
        end
        echo = 1'b0;
        @(negedge clock);
        resetn  = 1'b1;
        address = 32'h0;
        bus_read(32'h0000_0F01, 32'h0, 0, "post_reset_status");
        bus_read(32'h0000_0F02, 32'h0, 0, "post_reset_result");
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_measure();
        test_timeout();
        test_back_to_back();
        test_retrigger_ignored();
        test_reset_mid_measure();
        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
